// File: rtl/da_shift_accum.sv
// rtl/da_shift_accum.sv - DA FIR adder tree and bit-slice shift-accumulator with valid/ready output
// Optional macro DA_TREE_REG_EN registers the tree sum and slice flags for one stage.
module da_shift_accum #(
  parameter int DW   = 20,
  parameter int NBLK = 8,
  parameter int BITS = 16,
  parameter int OW   = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] q7,
  input  logic signed [DW-1:0] q6,
  input  logic signed [DW-1:0] q5,
  input  logic signed [DW-1:0] q4,
  input  logic signed [DW-1:0] q3,
  input  logic signed [DW-1:0] q2,
  input  logic signed [DW-1:0] q1,
  input  logic signed [DW-1:0] q0,
  input  logic                 q_valid,
  input  logic                 q_first,
  input  logic                 q_last,
  output logic signed [OW-1:0] y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic                 err,
  output logic                 ovf
);

  localparam int TW = DW + 3;
  localparam int AW = DW + 3 + BITS;
  localparam int KW = (BITS > 1) ? $clog2(BITS) + 1 : 1;

  localparam logic [0:0]    IDLE   = 1'b0;
  localparam logic [0:0]    ACC    = 1'b1;
  localparam logic [KW-1:0] K_LAST = KW'(BITS - 1);

  logic signed [DW-1:0]   q_arr [NBLK];
  logic signed [DW:0]     lvl1  [4];
  logic signed [DW+1:0]   lvl2  [2];
  logic signed [TW-1:0]   tree_sum;

  assign q_arr = '{q0, q1, q2, q3, q4, q5, q6, q7};

  // Each tree level grows by one bit, so the sum of eight inputs is exact in DW+3 bits.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl1[i] = {q_arr[2*i][DW-1], q_arr[2*i]} + {q_arr[2*i+1][DW-1], q_arr[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      lvl2[i] = {lvl1[2*i][DW], lvl1[2*i]} + {lvl1[2*i+1][DW], lvl1[2*i+1]};
    end
    tree_sum = {lvl2[0][DW+1], lvl2[0]} + {lvl2[1][DW+1], lvl2[1]};
  end

  logic signed [TW-1:0] s;
  logic                 sv;
  logic                 sf;
  logic                 sl;

`ifdef DA_TREE_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      s  <= '0;
      sv <= 1'b0;
      sf <= 1'b0;
      sl <= 1'b0;
    end else begin
      s  <= tree_sum;
      sv <= q_valid;
      sf <= q_first;
      sl <= q_last;
    end
  end
`else
  assign s  = tree_sum;
  assign sv = q_valid;
  assign sf = q_first;
  assign sl = q_last;
`endif

  logic [0:0]           state;
  logic [0:0]           state_nxt;
  logic [KW-1:0]        k;
  logic [KW-1:0]        k_nxt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt;
  logic signed [AW-1:0] s_ext;
  logic signed [AW-1:0] term;
  logic signed [AW-1:0] res;
  logic                 err_set;
  logic                 y_load;

  assign s_ext = AW'(s);
  assign term  = s_ext <<< k;
  // A first+last slice (single-slice frame) has no prior partial sum.
  assign res   = (sf ? AW'(0) : acc) - (s_ext <<< (BITS - 1));

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    k_nxt     = k;
    err_set   = 1'b0;
    y_load    = 1'b0;
    if (sv) begin
      if (sf && sl) begin
        state_nxt = IDLE;
        k_nxt     = '0;
        if (BITS == 1) begin
          y_load  = 1'b1;
          err_set = (state == ACC);
        end else begin
          err_set = 1'b1;
        end
      end else if (sf) begin
        acc_nxt   = s_ext;
        k_nxt     = KW'(1);
        state_nxt = ACC;
        err_set   = (state == ACC);
      end else if (state == IDLE) begin
        err_set = 1'b1;
      end else if (sl) begin
        state_nxt = IDLE;
        k_nxt     = '0;
        if (k == K_LAST) begin
          y_load = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end else if (k == K_LAST) begin
        err_set   = 1'b1;
        state_nxt = IDLE;
        k_nxt     = '0;
      end else begin
        acc_nxt = acc + term;
        k_nxt   = k + KW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      acc     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      err     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      acc   <= acc_nxt;
      if (err_set) begin
        err <= 1'b1;
      end
      if (y_load) begin
        y       <= OW'(res);
        y_valid <= 1'b1;
        if (y_valid && !y_ready) begin
          ovf <= 1'b1;
        end
      end else if (y_valid && y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_da_shift_accum.sv
// tb/tb_da_shift_accum.sv - directed table and random scoreboard bench for da_shift_accum
module tb_da_shift_accum;

  localparam int DW   = 20;
  localparam int BITS = 16;
  localparam int OW   = 40;
`ifdef DA_TREE_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] q [8];
  logic                 q_valid;
  logic                 q_first;
  logic                 q_last;
  logic signed [OW-1:0] y;
  logic                 y_valid;
  logic                 y_ready;
  logic                 err;
  logic                 ovf;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;

  typedef struct {
    int     all_v;
    int     lo_q0;
    int     msb_all;
    longint exp_y;
  } rec_t;

  rec_t   recs [9];
  longint sb [$];

  always #5 clk = ~clk;

  da_shift_accum #(.DW(DW), .NBLK(8), .BITS(BITS), .OW(OW)) dut (
    .clk(clk), .rst(rst),
    .q7(q[7]), .q6(q[6]), .q5(q[5]), .q4(q[4]),
    .q3(q[3]), .q2(q[2]), .q1(q[1]), .q0(q[0]),
    .q_valid(q_valid), .q_first(q_first), .q_last(q_last),
    .y(y), .y_valid(y_valid), .y_ready(y_ready),
    .err(err), .ovf(ovf)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int q_for(input int r, input int k, input int i);
    int v;
    v = recs[r].all_v;
    if (k == 0 && i == 0) v += recs[r].lo_q0;
    if (k == BITS - 1) v += recs[r].msb_all;
    return v;
  endfunction

  task automatic idle(input bit rdy);
    q_valid = 1'b0;
    q_first = 1'b0;
    q_last  = 1'b0;
    y_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic slice(input int r, input int k, input bit f, input bit l, input bit rdy);
    for (int i = 0; i < 8; i++) q[i] = DW'(q_for(r, k, i));
    q_valid = 1'b1;
    q_first = f;
    q_last  = l;
    y_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int r, input bit rdy_last);
    for (int k = 0; k < BITS; k++) begin
      slice(r, k, k == 0, k == BITS - 1, (k == BITS - 1) ? rdy_last : 1'b0);
    end
  endtask

  task automatic settle();
    repeat (LAT) idle(1'b0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    q_valid = 1'b0;
    q_first = 1'b0;
    q_last  = 1'b0;
    y_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One random-test cycle: y_ready is forced high every fourth cycle so no result is overrun.
  task automatic rstep(input bit v, input bit f, input bit l);
    q_valid = v;
    q_first = f;
    q_last  = l;
    y_ready = ((cyc % 4) == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (y_valid && y_ready) begin
      if (sb.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL rnd_extra: actual unexpected y %0d required no result", y);
      end else begin
        chk("rnd_y", y, sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_random();
    longint sk;
    longint expv;
    for (int n = 0; n < 12; n++) begin
      expv = 0;
      for (int k = 0; k < BITS; k++) begin
        while ($urandom_range(0, 3) == 0) rstep(1'b0, 1'b0, 1'b0);
        sk = 0;
        for (int i = 0; i < 8; i++) begin
          q[i] = DW'($urandom);
          sk += q[i];
        end
        expv += (k == BITS - 1) ? -(sk <<< k) : (sk <<< k);
        if (k == BITS - 1) sb.push_back(expv);
        rstep(1'b1, k == 0, k == BITS - 1);
      end
    end
    for (int t = 0; t < 60 && sb.size() > 0; t++) rstep(1'b0, 1'b0, 1'b0);
    chk("rnd_drain_left", sb.size(), 0);
    chk("rnd_err", err, 0);
    chk("rnd_ovf", ovf, 0);
  endtask

  initial begin
    recs[0] = '{1, 0, 0, -8};
    recs[1] = '{0, 5, 0, 5};
    recs[2] = '{0, 0, -1, 262144};
    recs[3] = '{-1, 0, 0, 8};
    recs[4] = '{0, 0, 0, 0};
    recs[5] = '{524287, 0, 0, -4194296};
    recs[6] = '{-524288, 0, 0, 4194304};
    recs[7] = '{0, 0, -524288, 64'sd137438953472};
    recs[8] = '{0, -524288, 0, -524288};

    rst     = 1'b1;
    q_valid = 1'b0;
    q_first = 1'b0;
    q_last  = 1'b0;
    y_ready = 1'b0;
    for (int i = 0; i < 8; i++) q[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_y", y, 0);
    chk("reset_y_valid", y_valid, 0);
    chk("reset_err", err, 0);
    chk("reset_ovf", ovf, 0);

    for (int r = 0; r < 9; r++) begin
      frame(r, 1'b0);
      chk("tab_latency", y_valid, longint'(LAT == 0));
      settle();
      chk("tab_y_valid", y_valid, 1);
      chk("tab_y", y, recs[r].exp_y);
      chk("tab_err", err, 0);
      idle(1'b1);
      chk("tab_accept", y_valid, 0);
    end

    do_reset();
    frame(0, 1'b0);
    frame(1, 1'b0);
    settle();
    chk("ovf_y", y, 5);
    chk("ovf_y_valid", y_valid, 1);
    chk("ovf_flag", ovf, 1);
    idle(1'b1);
    chk("ovf_accept", y_valid, 0);
    chk("ovf_sticky", ovf, 1);

    do_reset();
    for (int k = 0; k < 4; k++) slice(0, k, k == 0, k == 3, 1'b0);
    settle();
    idle(1'b0);
    chk("early_last_err", err, 1);
    chk("early_last_no_y", y_valid, 0);
    frame(1, 1'b0);
    settle();
    chk("early_last_next_y", y, 5);
    chk("early_last_next_valid", y_valid, 1);
    idle(1'b1);

    do_reset();
    for (int k = 0; k < 5; k++) slice(0, k, k == 0, 1'b0, 1'b0);
    frame(1, 1'b0);
    settle();
    chk("restart_err", err, 1);
    chk("restart_y", y, 5);
    idle(1'b1);

    do_reset();
    for (int k = 0; k < BITS; k++) slice(0, k, k == 0, 1'b0, 1'b0);
    settle();
    idle(1'b0);
    chk("missing_last_err", err, 1);
    chk("missing_last_no_y", y_valid, 0);

    do_reset();
    slice(1, 0, 1'b1, 1'b1, 1'b0);
    settle();
    idle(1'b0);
    chk("first_last_err", err, 1);
    chk("first_last_no_y", y_valid, 0);

    do_reset();
    for (int k = 0; k < 8; k++) slice(0, k, k == 0, 1'b0, 1'b0);
    do_reset();
    frame(1, 1'b0);
    settle();
    chk("midrst_y", y, 5);
    chk("midrst_y_valid", y_valid, 1);
    chk("midrst_err", err, 0);
    chk("midrst_ovf", ovf, 0);

    frame(0, 1'b1 & (LAT == 0));
    repeat (LAT) idle(1'b1);
    chk("same_cycle_y", y, -8);
    chk("same_cycle_y_valid", y_valid, 1);
    chk("same_cycle_ovf", ovf, 0);
    idle(1'b1);
    chk("same_cycle_accept", y_valid, 0);

    do_reset();
    cyc = 0;
    run_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
